// File: rtl/fetch_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fetch_scheduler_pkg
//   Shared definitions for the fetch scheduler and its arbiter: the per-slot
//   fetch state encodings and the default sizing parameters.
// ----------------------------------------------------------------------------
package fetch_scheduler_pkg;

   // Default sizing
   localparam int NUM_WF_DEF      = 40;
   localparam int WF_ID_W_DEF     = 6;
   localparam int PC_W_DEF        = 32;
   localparam int FETCH_BYTES_DEF = 4;

   // Per-slot fetch state
   typedef logic [1:0] fs_state_t;

   localparam fs_state_t FS_IDLE    = 2'd0;  // no resident wavefront
   localparam fs_state_t FS_READY   = 2'd1;  // resident, no fetch outstanding
   localparam fs_state_t FS_PEND    = 2'd2;  // fetch issued, response expected
   localparam fs_state_t FS_DISCARD = 2'd3;  // outstanding response will be dropped

endpackage : fetch_scheduler_pkg

// File: rtl/fetch_scheduler_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Searches the request vector starting
//   at the pointer position and wrapping at NUM_WF; the first set request wins.
//
// Ports:
//   req        in   NUM_WF  request vector
//   ptr        in   ID_W    slot with highest priority (must be < NUM_WF)
//   grant      out  NUM_WF  one-hot grant
//   grant_id   out  ID_W    encoded index of the granted slot
//   any_grant  out  1       at least one request was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_WF = 40,
   parameter int ID_W   = 6
) (
   input  logic [NUM_WF-1:0] req,
   input  logic [ID_W-1:0]   ptr,
   output logic [NUM_WF-1:0] grant,
   output logic [ID_W-1:0]   grant_id,
   output logic              any_grant
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop, so no path leaves
      // a value unassigned and no latch is inferred.
      grant     = '0;
      grant_id  = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_WF; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_WF) idx = idx - NUM_WF;
         if (!any_grant && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            any_grant  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/fetch_scheduler.sv
// ----------------------------------------------------------------------------
// fetch_scheduler
//   Tracks fetch state and PC for up to NUM_WF resident wavefronts, issues at
//   most one outstanding instruction fetch per wavefront (round-robin, gated
//   by instruction-buffer credit), and handles redirects and halts. Returned
//   fetches for live slots pulse the instruction-buffer write and wave-reserve
//   strobes one cycle later.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   dispatch_valid_i/_wf_id_i/_pc_i   new wavefront into an IDLE slot
//   buff_credit_i              per-slot instruction buffer has space
//   redirect_valid_i/_wf_id_i/_pc_i   branch/jump PC update
//   halt_valid_i/_wf_id_i      wavefront ended
//   fetch_req_valid_o/_wf_id_o/_pc_o, fetch_req_ready_i   fetch request
//   fetch_resp_valid_i/_wf_id_i       fetch data returned
//   inst_buff_wr_o/_wf_id_o    instruction buffer write strobe
//   wave_reserve_valid_o/_wf_id_o     wavepool reserve strobe
//   active_wf_o                slot is not IDLE
// ----------------------------------------------------------------------------
module fetch_scheduler
   import fetch_scheduler_pkg::*;
#(
   parameter int NUM_WF      = NUM_WF_DEF,
   parameter int WF_ID_W     = WF_ID_W_DEF,
   parameter int PC_W        = PC_W_DEF,
   parameter int FETCH_BYTES = FETCH_BYTES_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               dispatch_valid_i,
   input  logic [WF_ID_W-1:0] dispatch_wf_id_i,
   input  logic [PC_W-1:0]    dispatch_pc_i,
   input  logic [NUM_WF-1:0]  buff_credit_i,
   input  logic               redirect_valid_i,
   input  logic [WF_ID_W-1:0] redirect_wf_id_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   input  logic               halt_valid_i,
   input  logic [WF_ID_W-1:0] halt_wf_id_i,
   output logic               fetch_req_valid_o,
   input  logic               fetch_req_ready_i,
   output logic [WF_ID_W-1:0] fetch_req_wf_id_o,
   output logic [PC_W-1:0]    fetch_req_pc_o,
   input  logic               fetch_resp_valid_i,
   input  logic [WF_ID_W-1:0] fetch_resp_wf_id_i,
   output logic               inst_buff_wr_o,
   output logic [WF_ID_W-1:0] inst_buff_wf_id_o,
   output logic               wave_reserve_valid_o,
   output logic [WF_ID_W-1:0] wave_reserve_wf_id_o,
   output logic [NUM_WF-1:0]  active_wf_o
);

   // Per-slot state
   fs_state_t         state_q [NUM_WF];
   fs_state_t         state_d [NUM_WF];
   logic [PC_W-1:0]   pc_q    [NUM_WF];
   logic [PC_W-1:0]   pc_d    [NUM_WF];
   logic [NUM_WF-1:0] halted_q;   // DISCARD slot is draining toward IDLE
   logic [NUM_WF-1:0] halted_d;

   // Arbitration and request register
   logic [WF_ID_W-1:0] rr_ptr_q;
   logic               req_valid_q;
   logic [WF_ID_W-1:0] req_wf_id_q;
   logic [PC_W-1:0]    req_pc_q;
   logic               strobe_q;
   logic [WF_ID_W-1:0] strobe_wf_id_q;

   // Per-slot event decodes
   logic [NUM_WF-1:0] disp_hit, redir_hit, halt_hit, resp_hit, acc_hit;
   logic [NUM_WF-1:0] pend_vec, eligible, grant_oh;
   logic [WF_ID_W-1:0] grant_id;
   logic               any_grant;
   logic               can_grant, grant_fire, accept, resp_ok;

   assign accept     = req_valid_q && fetch_req_ready_i;
   // The request register may be reloaded in the same cycle it is accepted.
   assign can_grant  = !req_valid_q || fetch_req_ready_i;
   assign grant_fire = any_grant && can_grant;

   always_comb begin
      disp_hit  = '0;
      redir_hit = '0;
      halt_hit  = '0;
      resp_hit  = '0;
      acc_hit   = '0;
      pend_vec  = '0;
      eligible  = '0;
      for (int w = 0; w < NUM_WF; w++) begin
         disp_hit[w]  = dispatch_valid_i   && (dispatch_wf_id_i   == WF_ID_W'(w));
         redir_hit[w] = redirect_valid_i   && (redirect_wf_id_i   == WF_ID_W'(w));
         halt_hit[w]  = halt_valid_i       && (halt_wf_id_i       == WF_ID_W'(w));
         resp_hit[w]  = fetch_resp_valid_i && (fetch_resp_wf_id_i == WF_ID_W'(w));
         acc_hit[w]   = accept             && (req_wf_id_q        == WF_ID_W'(w));
         pend_vec[w]  = (state_q[w] == FS_PEND);
         // A slot touched by halt or redirect this cycle must not start a fetch
         // from a PC that is about to change.
         eligible[w]  = (state_q[w] == FS_READY) && buff_credit_i[w] &&
                        !halt_hit[w] && !redir_hit[w];
      end
   end

   // Only a response to a live PEND slot reaches the instruction buffer.
   assign resp_ok = |(resp_hit & pend_vec & ~halt_hit & ~redir_hit);

   rr_arbiter #(
      .NUM_WF (NUM_WF),
      .ID_W   (WF_ID_W)
   ) u_rr (
      .req       (eligible),
      .ptr       (rr_ptr_q),
      .grant     (grant_oh),
      .grant_id  (grant_id),
      .any_grant (any_grant)
   );

   // Slot next-state; priority per slot is halt > redirect > response > grant.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      for (int w = 0; w < NUM_WF; w++) begin
         case (state_q[w])
            FS_IDLE: begin
               if (disp_hit[w]) begin
                  state_d[w]  = FS_READY;
                  pc_d[w]     = dispatch_pc_i;
                  halted_d[w] = 1'b0;
               end
            end
            FS_READY: begin
               if (halt_hit[w])                   state_d[w] = FS_IDLE;
               else if (redir_hit[w])             pc_d[w]    = redirect_pc_i;
               else if (grant_fire && grant_oh[w]) state_d[w] = FS_PEND;
            end
            FS_PEND: begin
               if (halt_hit[w]) begin
                  if (resp_hit[w]) state_d[w] = FS_IDLE;
                  else begin
                     state_d[w]  = FS_DISCARD;
                     halted_d[w] = 1'b1;
                  end
               end else if (redir_hit[w]) begin
                  pc_d[w]    = redirect_pc_i;
                  state_d[w] = resp_hit[w] ? FS_READY : FS_DISCARD;
               end else if (resp_hit[w]) begin
                  state_d[w] = FS_READY;
               end else if (acc_hit[w]) begin
                  pc_d[w] = pc_q[w] + PC_W'(FETCH_BYTES);
               end
            end
            FS_DISCARD: begin
               if (halted_q[w] || halt_hit[w]) begin
                  halted_d[w] = 1'b1;
                  if (resp_hit[w]) begin
                     state_d[w]  = FS_IDLE;
                     halted_d[w] = 1'b0;
                  end
               end else begin
                  if (redir_hit[w]) pc_d[w]    = redirect_pc_i;
                  if (resp_hit[w])  state_d[w] = FS_READY;
               end
            end
            default: state_d[w] = FS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the PC array is cleared here because a slot's PC is defined
         // to read 0 out of reset; a pure data array would normally be left
         // unreset.
         for (int w = 0; w < NUM_WF; w++) begin
            state_q[w] <= FS_IDLE;
            pc_q[w]    <= '0;
         end
         halted_q       <= '0;
         rr_ptr_q       <= '0;
         req_valid_q    <= 1'b0;
         req_wf_id_q    <= '0;
         req_pc_q       <= '0;
         strobe_q       <= 1'b0;
         strobe_wf_id_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based on
         // pre-edge values regardless of statement order.
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         if (grant_fire) begin
            req_valid_q <= 1'b1;
            req_wf_id_q <= grant_id;
            req_pc_q    <= pc_q[grant_id];
            rr_ptr_q    <= (grant_id == WF_ID_W'(NUM_WF - 1)) ? '0
                                                               : grant_id + WF_ID_W'(1);
         end else if (accept) begin
            req_valid_q <= 1'b0;
         end
         strobe_q       <= resp_ok;
         strobe_wf_id_q <= resp_ok ? fetch_resp_wf_id_i : '0;
      end
   end

   assign fetch_req_valid_o    = req_valid_q;
   assign fetch_req_wf_id_o    = req_wf_id_q;
   assign fetch_req_pc_o       = req_pc_q;
   assign inst_buff_wr_o       = strobe_q;
   assign inst_buff_wf_id_o    = strobe_wf_id_q;
   assign wave_reserve_valid_o = strobe_q;
   assign wave_reserve_wf_id_o = strobe_wf_id_q;

   always_comb begin
      active_wf_o = '0;
      for (int w = 0; w < NUM_WF; w++) active_wf_o[w] = (state_q[w] != FS_IDLE);
   end

endmodule : fetch_scheduler

// File: tb/tb_fetch_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fetch_scheduler
//   Self-checking bench for fetch_scheduler: a vector table for the basic
//   fetch/response flow, hand-written sequences for the multi-cycle corner
//   cases, and a randomized run against a slot-level reference model.
// ----------------------------------------------------------------------------
module tb_fetch_scheduler;
   import fetch_scheduler_pkg::*;

   localparam int NW = 40;
   localparam int IW = 6;
   localparam int PW = 32;
   localparam int FB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          dispatch_valid_i;
   logic [IW-1:0] dispatch_wf_id_i;
   logic [PW-1:0] dispatch_pc_i;
   logic [NW-1:0] buff_credit_i;
   logic          redirect_valid_i;
   logic [IW-1:0] redirect_wf_id_i;
   logic [PW-1:0] redirect_pc_i;
   logic          halt_valid_i;
   logic [IW-1:0] halt_wf_id_i;
   logic          fetch_req_valid_o;
   logic          fetch_req_ready_i;
   logic [IW-1:0] fetch_req_wf_id_o;
   logic [PW-1:0] fetch_req_pc_o;
   logic          fetch_resp_valid_i;
   logic [IW-1:0] fetch_resp_wf_id_i;
   logic          inst_buff_wr_o;
   logic [IW-1:0] inst_buff_wf_id_o;
   logic          wave_reserve_valid_o;
   logic [IW-1:0] wave_reserve_wf_id_o;
   logic [NW-1:0] active_wf_o;

   fetch_scheduler #(
      .NUM_WF(NW), .WF_ID_W(IW), .PC_W(PW), .FETCH_BYTES(FB)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .dispatch_valid_i     (dispatch_valid_i),
      .dispatch_wf_id_i     (dispatch_wf_id_i),
      .dispatch_pc_i        (dispatch_pc_i),
      .buff_credit_i        (buff_credit_i),
      .redirect_valid_i     (redirect_valid_i),
      .redirect_wf_id_i     (redirect_wf_id_i),
      .redirect_pc_i        (redirect_pc_i),
      .halt_valid_i         (halt_valid_i),
      .halt_wf_id_i         (halt_wf_id_i),
      .fetch_req_valid_o    (fetch_req_valid_o),
      .fetch_req_ready_i    (fetch_req_ready_i),
      .fetch_req_wf_id_o    (fetch_req_wf_id_o),
      .fetch_req_pc_o       (fetch_req_pc_o),
      .fetch_resp_valid_i   (fetch_resp_valid_i),
      .fetch_resp_wf_id_i   (fetch_resp_wf_id_i),
      .inst_buff_wr_o       (inst_buff_wr_o),
      .inst_buff_wf_id_o    (inst_buff_wf_id_o),
      .wave_reserve_valid_o (wave_reserve_valid_o),
      .wave_reserve_wf_id_o (wave_reserve_wf_id_o),
      .active_wf_o          (active_wf_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Inputs change right after a falling edge; outputs are sampled there too.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_pulses();
      dispatch_valid_i   = 1'b0;
      dispatch_wf_id_i   = '0;
      dispatch_pc_i      = '0;
      redirect_valid_i   = 1'b0;
      redirect_wf_id_i   = '0;
      redirect_pc_i      = '0;
      halt_valid_i       = 1'b0;
      halt_wf_id_i       = '0;
      fetch_resp_valid_i = 1'b0;
      fetch_resp_wf_id_i = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_pulses();
      buff_credit_i     = '1;
      fetch_req_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic dispatch(input int id, input logic [PW-1:0] pc);
      dispatch_valid_i = 1'b1;
      dispatch_wf_id_i = IW'(id);
      dispatch_pc_i    = pc;
   endtask

   // ---------------- vector table for the basic flow ----------------
   typedef struct {
      logic          dv;
      logic [IW-1:0] did;
      logic [PW-1:0] dpc;
      logic          rdy;
      logic          rsv;
      logic [IW-1:0] rsid;
      logic          e_req;
      logic [IW-1:0] e_id;
      logic [PW-1:0] e_pc;
      logic          e_wr;
      logic [IW-1:0] e_wid;
   } vec_t;

   vec_t vt [8];

   // ---------------- reference model (slot-level) ----------------
   bit            m_res     [NW];  // wavefront resident
   bit            m_busy    [NW];  // one fetch granted and not yet answered
   bit            m_drop    [NW];  // answer to that fetch is to be thrown away
   bit            m_halting [NW];  // wavefront ended, waiting for the last answer
   bit            m_acc     [NW];  // fetch accepted by memory, answer may come
   logic [PW-1:0] m_pc      [NW];
   bit            m_req_v;
   int            m_req_id;
   logic [PW-1:0] m_req_pc;
   int            m_ptr;
   bit            m_wr;
   int            m_wr_id;

   task automatic model_init();
      for (int w = 0; w < NW; w++) begin
         m_res[w] = 0; m_busy[w] = 0; m_drop[w] = 0; m_halting[w] = 0;
         m_acc[w] = 0; m_pc[w] = '0;
      end
      m_req_v = 0; m_req_id = 0; m_req_pc = '0; m_ptr = 0; m_wr = 0; m_wr_id = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int  g;
      bit  acc;
      int  acc_id;
      int  rs;
      bit  h, r, s, a, d;
      g      = -1;
      acc    = m_req_v && fetch_req_ready_i;
      acc_id = m_req_id;
      rs     = int'(fetch_resp_wf_id_i);
      if (!m_req_v || fetch_req_ready_i) begin
         for (int k = 0; k < NW; k++) begin
            int w;
            w = (m_ptr + k) % NW;
            if (g < 0 && m_res[w] && !m_busy[w] && buff_credit_i[w] &&
                !(halt_valid_i && halt_wf_id_i == IW'(w)) &&
                !(redirect_valid_i && redirect_wf_id_i == IW'(w)))
               g = w;
         end
      end
      m_wr = fetch_resp_valid_i && rs < NW && m_res[rs] && m_busy[rs] && !m_drop[rs] &&
             !(halt_valid_i && halt_wf_id_i == IW'(rs)) &&
             !(redirect_valid_i && redirect_wf_id_i == IW'(rs));
      if (m_wr) m_wr_id = rs;
      if (g >= 0) begin
         m_req_v  = 1;
         m_req_id = g;
         m_req_pc = m_pc[g];
         m_ptr    = (g + 1) % NW;
      end else if (acc) begin
         m_req_v = 0;
      end
      for (int w = 0; w < NW; w++) begin
         h = halt_valid_i       && halt_wf_id_i       == IW'(w);
         r = redirect_valid_i   && redirect_wf_id_i   == IW'(w);
         s = fetch_resp_valid_i && fetch_resp_wf_id_i == IW'(w);
         a = acc && acc_id == w;
         d = dispatch_valid_i   && dispatch_wf_id_i   == IW'(w);
         if (!m_res[w]) begin
            if (d) begin
               m_res[w] = 1; m_busy[w] = 0; m_drop[w] = 0; m_halting[w] = 0;
               m_pc[w] = dispatch_pc_i;
            end
         end else if (!m_busy[w]) begin
            if (h)           m_res[w]  = 0;
            else if (r)      m_pc[w]   = redirect_pc_i;
            else if (g == w) m_busy[w] = 1;
         end else if (m_halting[w]) begin
            if (s) begin m_res[w] = 0; m_busy[w] = 0; m_drop[w] = 0; m_halting[w] = 0; end
         end else if (h) begin
            if (s) begin m_res[w] = 0; m_busy[w] = 0; m_drop[w] = 0; end
            else begin m_drop[w] = 1; m_halting[w] = 1; end
         end else if (r) begin
            m_pc[w] = redirect_pc_i;
            if (s) begin m_busy[w] = 0; m_drop[w] = 0; end
            else m_drop[w] = 1;
         end else if (s) begin
            m_busy[w] = 0; m_drop[w] = 0;
         end else if (a && !m_drop[w]) begin
            m_pc[w] = m_pc[w] + PW'(FB);
         end
      end
      if (fetch_resp_valid_i && rs < NW) m_acc[rs] = 0;
      if (acc) m_acc[acc_id] = 1;
   endtask

   task automatic model_compare();
      logic [NW-1:0] exp_act;
      exp_act = '0;
      for (int w = 0; w < NW; w++) exp_act[w] = m_res[w];
      check("rnd_req_valid", 64'(fetch_req_valid_o), 64'(m_req_v));
      if (m_req_v) begin
         check("rnd_req_id", 64'(fetch_req_wf_id_o), 64'(m_req_id));
         check("rnd_req_pc", 64'(fetch_req_pc_o), 64'(m_req_pc));
      end
      check("rnd_ibuf_wr", 64'(inst_buff_wr_o), 64'(m_wr));
      check("rnd_reserve", 64'(wave_reserve_valid_o), 64'(m_wr));
      if (m_wr) begin
         check("rnd_ibuf_id", 64'(inst_buff_wf_id_o), 64'(m_wr_id));
         check("rnd_reserve_id", 64'(wave_reserve_wf_id_o), 64'(m_wr_id));
      end
      check("rnd_active", 64'(active_wf_o), 64'(exp_act));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int order [$];
      int exp_order [6];
      bit have_last;
      int last_id;
      bit seen;
      int q [$];

      // ---------- reset state ----------
      do_reset();
      check("reset_req_valid", 64'(fetch_req_valid_o), 64'd0);
      check("reset_ibuf_wr",   64'(inst_buff_wr_o),    64'd0);
      check("reset_active",    64'(active_wf_o),       64'd0);

      // ---------- reset while a request is outstanding ----------
      fetch_req_ready_i = 1'b0;
      dispatch(1, 32'h40);
      tick();
      clear_pulses();
      tick();
      check("midreset_pre_req", 64'(fetch_req_valid_o), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_req_valid", 64'(fetch_req_valid_o),    64'd0);
      check("midreset_req_id",    64'(fetch_req_wf_id_o),    64'd0);
      check("midreset_req_pc",    64'(fetch_req_pc_o),       64'd0);
      check("midreset_ibuf_wr",   64'(inst_buff_wr_o),       64'd0);
      check("midreset_reserve",   64'(wave_reserve_valid_o), 64'd0);
      check("midreset_active",    64'(active_wf_o),          64'd0);

      // ---------- basic flow from the vector table ----------
      //         dv did dpc     rdy rsv rsid  e_req e_id e_pc     e_wr e_wid
      vt[0] = '{1, 3, 32'h100, 1, 0, 0,    0, 0, 32'h0,   0, 0};
      vt[1] = '{0, 0, 32'h0,   1, 0, 0,    1, 3, 32'h100, 0, 0};
      vt[2] = '{0, 0, 32'h0,   1, 0, 0,    0, 0, 32'h0,   0, 0};
      vt[3] = '{0, 0, 32'h0,   1, 1, 3,    0, 0, 32'h0,   1, 3};
      vt[4] = '{0, 0, 32'h0,   1, 0, 0,    1, 3, 32'h104, 0, 0};
      vt[5] = '{0, 0, 32'h0,   0, 0, 0,    1, 3, 32'h104, 0, 0};
      vt[6] = '{0, 0, 32'h0,   1, 0, 0,    0, 0, 32'h0,   0, 0};
      vt[7] = '{0, 0, 32'h0,   1, 1, 3,    0, 0, 32'h0,   1, 3};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         clear_pulses();
         dispatch_valid_i   = vt[i].dv;
         dispatch_wf_id_i   = vt[i].did;
         dispatch_pc_i      = vt[i].dpc;
         fetch_req_ready_i  = vt[i].rdy;
         fetch_resp_valid_i = vt[i].rsv;
         fetch_resp_wf_id_i = vt[i].rsid;
         tick();
         check($sformatf("vec%0d_req_valid", i), 64'(fetch_req_valid_o), 64'(vt[i].e_req));
         if (vt[i].e_req) begin
            check($sformatf("vec%0d_req_id", i), 64'(fetch_req_wf_id_o), 64'(vt[i].e_id));
            check($sformatf("vec%0d_req_pc", i), 64'(fetch_req_pc_o),    64'(vt[i].e_pc));
         end
         check($sformatf("vec%0d_ibuf_wr", i), 64'(inst_buff_wr_o),       64'(vt[i].e_wr));
         check($sformatf("vec%0d_reserve", i), 64'(wave_reserve_valid_o), 64'(vt[i].e_wr));
         if (vt[i].e_wr) begin
            check($sformatf("vec%0d_ibuf_id", i),    64'(inst_buff_wf_id_o),    64'(vt[i].e_wid));
            check($sformatf("vec%0d_reserve_id", i), 64'(wave_reserve_wf_id_o), 64'(vt[i].e_wid));
         end
      end

      // ---------- round-robin order 0,1,2,0,1,2 ----------
      do_reset();
      exp_order = '{0, 1, 2, 0, 1, 2};
      have_last = 0;
      last_id   = 0;
      for (int c = 0; c < 40 && order.size() < 6; c++) begin
         clear_pulses();
         if (c < 3) dispatch(c, PW'(32'h1000 * (c + 1)));
         if (have_last) begin
            fetch_resp_valid_i = 1'b1;
            fetch_resp_wf_id_i = IW'(last_id);
         end
         have_last = 0;
         if (fetch_req_valid_o) begin
            order.push_back(int'(fetch_req_wf_id_o));
            last_id   = int'(fetch_req_wf_id_o);
            have_last = 1;
         end
         tick();
      end
      check("rr_grant_count", 64'(order.size()), 64'd6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         check($sformatf("rr_grant%0d", i), 64'(order[i]), 64'(exp_order[i]));

      // ---------- back-pressure holds the request ----------
      do_reset();
      fetch_req_ready_i = 1'b0;
      dispatch(5, 32'h500);
      tick();
      clear_pulses();
      dispatch(6, 32'h600);
      tick();
      clear_pulses();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold%0d_valid", i), 64'(fetch_req_valid_o), 64'd1);
         check($sformatf("hold%0d_id", i),    64'(fetch_req_wf_id_o), 64'd5);
         check($sformatf("hold%0d_pc", i),    64'(fetch_req_pc_o),    64'h500);
         tick();
      end
      fetch_req_ready_i = 1'b1;
      tick();
      check("hold_next_valid", 64'(fetch_req_valid_o), 64'd1);
      check("hold_next_id",    64'(fetch_req_wf_id_o), 64'd6);
      check("hold_next_pc",    64'(fetch_req_pc_o),    64'h600);

      // ---------- redirect while pending ----------
      do_reset();
      dispatch(7, 32'h200);
      tick();
      clear_pulses();
      tick();
      check("redir_first_pc", 64'(fetch_req_pc_o), 64'h200);
      tick();                                   // accepted, slot 7 pending
      redirect_valid_i = 1'b1;
      redirect_wf_id_i = 6'd7;
      redirect_pc_i    = 32'h400;
      tick();
      clear_pulses();
      fetch_resp_valid_i = 1'b1;
      fetch_resp_wf_id_i = 6'd7;
      tick();
      clear_pulses();
      check("redir_resp_no_wr",      64'(inst_buff_wr_o),       64'd0);
      check("redir_resp_no_reserve", 64'(wave_reserve_valid_o), 64'd0);
      tick();
      check("redir_next_valid", 64'(fetch_req_valid_o), 64'd1);
      check("redir_next_id",    64'(fetch_req_wf_id_o), 64'd7);
      check("redir_next_pc",    64'(fetch_req_pc_o),    64'h400);

      // ---------- halt while pending drains to IDLE ----------
      do_reset();
      dispatch(2, 32'h80);
      tick();
      clear_pulses();
      tick();
      tick();                                   // accepted, slot 2 pending
      halt_valid_i = 1'b1;
      halt_wf_id_i = 6'd2;
      tick();
      clear_pulses();
      check("halt_drain_active", 64'(active_wf_o[2]), 64'd1);
      fetch_resp_valid_i = 1'b1;
      fetch_resp_wf_id_i = 6'd2;
      tick();
      clear_pulses();
      check("halt_resp_no_wr",  64'(inst_buff_wr_o), 64'd0);
      check("halt_idle_active", 64'(active_wf_o[2]), 64'd0);
      tick();
      check("halt_no_refetch", 64'(fetch_req_valid_o), 64'd0);

      // ---------- credit gating ----------
      do_reset();
      buff_credit_i    = '1;
      buff_credit_i[4] = 1'b0;
      dispatch(4, 32'hC00);
      tick();
      clear_pulses();
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (fetch_req_valid_o) seen = 1;
      end
      check("credit0_no_req", 64'(seen), 64'd0);
      buff_credit_i[4] = 1'b1;
      seen = 0;
      for (int i = 0; i < 5 && !seen; i++) begin
         tick();
         if (fetch_req_valid_o) seen = 1;
      end
      check("credit1_req_seen", 64'(seen), 64'd1);
      check("credit1_req_id",   64'(fetch_req_wf_id_o), 64'd4);
      check("credit1_req_pc",   64'(fetch_req_pc_o),    64'hC00);

      // ---------- randomized run against the model ----------
      do_reset();
      model_init();
      for (int c = 0; c < 3000; c++) begin
         model_compare();
         clear_pulses();
         if ($urandom_range(1, 0) == 1)
            dispatch($urandom_range(NW - 1, 0), PW'($urandom()) & ~PW'(3));
         if ($urandom_range(9, 0) == 0) begin
            redirect_valid_i = 1'b1;
            redirect_wf_id_i = IW'($urandom_range(NW - 1, 0));
            redirect_pc_i    = PW'($urandom()) & ~PW'(3);
         end
         if ($urandom_range(19, 0) == 0) begin
            halt_valid_i = 1'b1;
            halt_wf_id_i = IW'($urandom_range(NW - 1, 0));
         end
         for (int w = 0; w < NW; w++) buff_credit_i[w] = ($urandom_range(9, 0) != 0);
         fetch_req_ready_i = ($urandom_range(9, 0) < 7);
         q.delete();
         for (int w = 0; w < NW; w++) if (m_acc[w]) q.push_back(w);
         if (q.size() > 0 && $urandom_range(1, 0) == 1) begin
            fetch_resp_valid_i = 1'b1;
            fetch_resp_wf_id_i = IW'(q[$urandom_range(q.size() - 1, 0)]);
         end
         model_step();
         tick();
      end
      model_compare();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fetch_scheduler
